// File: rtl/int_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : int_controller                                                  |
// | Purpose  : Prioritised, maskable interrupt controller. Edge-detects        |
// |            peripheral lines into a pending register, presents one request  |
// |            with its handler vector, and tracks it until end-of-interrupt.  |
// | Options  : INT_ROTATE_PRI_EN - rotating priority (default: fixed, id 0     |
// |            highest).                                                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module int_controller #(
  parameter int NUM_IRQ   = 8,
  parameter int VEC_SHIFT = 2,
  parameter int DATA_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  i_irq_in,
  input  logic                i_cfg_we,
  input  logic                i_cfg_re,
  input  logic [1:0]          i_cfg_addr,
  input  logic [DATA_W-1:0]   i_cfg_wdata,
  output logic [DATA_W-1:0]   o_cfg_rdata,
  output logic                o_int_req,
  output logic [DATA_W-1:0]   o_int_vector,
  input  logic                i_int_ack,
  input  logic                i_int_eoi
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] c_ADDR_MASK    = 2'd0;
  localparam logic [1:0] c_ADDR_PENDING = 2'd1;
  localparam logic [1:0] c_ADDR_BASE    = 2'd2;

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_IRQ-1:0]  r_mask;
  logic [NUM_IRQ-1:0]  r_pending;
  logic [NUM_IRQ-1:0]  r_irq_prev;
  logic [DATA_W-1:0]   r_base;
  logic [2:0]          r_sel_id;
  logic [DATA_W-1:0]   r_vector;
  logic [DATA_W-1:0]   r_rdata;

  logic [NUM_IRQ-1:0]  w_edge;
  logic [NUM_IRQ-1:0]  w_active;
  logic [NUM_IRQ-1:0]  w_pending_next;
  logic [7:0]          w_sel_onehot;
  logic                w_win_valid;
  logic [2:0]          w_win_id;
  logic                w_latch;
  logic                w_take;
  logic [DATA_W-1:0]   w_rdata_sel;
  logic [5:0]          w_status;

  assign w_edge   = i_irq_in & ~r_irq_prev;
  assign w_active = r_pending & ~r_mask;

`ifdef INT_ROTATE_PRI_EN
  logic [2:0] r_ptr;
  logic [7:0] w_act8;
  logic [3:0] w_ptr_inc;

  assign w_act8    = 8'(w_active);
  assign w_ptr_inc = {1'b0, r_sel_id} + 4'd1;

  // Rotating arbiter: scan downward from the farthest offset so the closest to r_ptr wins
  always_comb begin
    logic [3:0] v_idx;
    w_win_valid = 1'b0;
    w_win_id    = 3'd0;
    v_idx       = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      v_idx = {1'b0, r_ptr} + 4'(i);
      if (v_idx >= 4'(NUM_IRQ)) v_idx = v_idx - 4'(NUM_IRQ);
      if (w_act8[v_idx[2:0]]) begin
        w_win_valid = 1'b1;
        w_win_id    = v_idx[2:0];
      end
    end
  end

  // Priority pointer moves to the line just after the one taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 3'd0;
    end else if (w_take) begin
      r_ptr <= (w_ptr_inc >= 4'(NUM_IRQ)) ? 3'd0 : w_ptr_inc[2:0];
    end
  end
`else
  // Fixed arbiter: lowest-numbered unmasked pending line wins
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_win_valid = 1'b1;
        w_win_id    = 3'(i);
      end
    end
  end
`endif

  // Next-state and handshake qualifiers; ack/eoi only act in their own state
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_take       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_valid) begin
          w_latch      = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_int_ack) begin
          w_take       = 1'b1;
          w_state_next = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (i_int_eoi) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_sel_onehot = 8'd1 << r_sel_id;

  // Pending update: W1C and ack clear first, then new edges set so a same-cycle edge wins
  always_comb begin
    w_pending_next = r_pending;
    if (i_cfg_we && (i_cfg_addr == c_ADDR_PENDING))
      w_pending_next = w_pending_next & ~i_cfg_wdata[NUM_IRQ-1:0];
    if (w_take)
      w_pending_next = w_pending_next & ~w_sel_onehot[NUM_IRQ-1:0];
    w_pending_next = w_pending_next | w_edge;
  end

  assign w_status = {(r_state == ST_SERVICE), r_state, r_sel_id};

  // Config read mux; unused high bits are zero-extended
  always_comb begin
    case (i_cfg_addr)
      c_ADDR_MASK:    w_rdata_sel = DATA_W'(r_mask);
      c_ADDR_PENDING: w_rdata_sel = DATA_W'(r_pending);
      c_ADDR_BASE:    w_rdata_sel = r_base;
      default:        w_rdata_sel = DATA_W'(w_status);
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Datapath registers: config, pending, edge history, selection and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask     <= '1;
      r_pending  <= '0;
      r_irq_prev <= '0;
      r_base     <= '0;
      r_sel_id   <= 3'd0;
      r_vector   <= '0;
      r_rdata    <= '0;
    end else begin
      r_irq_prev <= i_irq_in;
      r_pending  <= w_pending_next;
      if (i_cfg_we && (i_cfg_addr == c_ADDR_MASK)) r_mask <= i_cfg_wdata[NUM_IRQ-1:0];
      if (i_cfg_we && (i_cfg_addr == c_ADDR_BASE)) r_base <= i_cfg_wdata;
      if (i_cfg_re) r_rdata <= w_rdata_sel;
      // Vector is frozen at selection so it stays stable for the whole request
      if (w_latch) begin
        r_sel_id <= w_win_id;
        r_vector <= r_base + (DATA_W'(w_win_id) << VEC_SHIFT);
      end
    end
  end

  assign o_int_req    = (r_state == ST_REQ);
  assign o_int_vector = r_vector;
  assign o_cfg_rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_int_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_int_controller                                               |
// | Purpose  : Self-checking bench for int_controller: directed scenarios and  |
// |            a randomized run against a behavioural reference model.        |
// | Options  : INT_ROTATE_PRI_EN selects rotating-priority expectations.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_int_controller;
  localparam int NUM_IRQ   = 8;
  localparam int VEC_SHIFT = 2;
  localparam int DATA_W    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq = '0;
  logic        we = 1'b0, re = 1'b0, ack = 1'b0, eoi = 1'b0;
  logic [1:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata, vector;
  logic        req;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state (plain integers)
  int m_mask, m_pend, m_base, m_prev, m_phase, m_sel, m_vec, m_ptr, m_rdata;

  always #5 clk = ~clk;

  int_controller #(.NUM_IRQ(NUM_IRQ), .VEC_SHIFT(VEC_SHIFT), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .i_irq_in(irq), .i_cfg_we(we), .i_cfg_re(re),
    .i_cfg_addr(addr), .i_cfg_wdata(wdata), .o_cfg_rdata(rdata),
    .o_int_req(req), .o_int_vector(vector), .i_int_ack(ack), .i_int_eoi(eoi)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; irq = '0; we = 1'b0; re = 1'b0; ack = 1'b0; eoi = 1'b0; addr = '0; wdata = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick;
    we = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [15:0] d);
    re = 1'b1; addr = a;
    tick;
    re = 1'b0;
    d = rdata;
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    irq = m; tick; irq = '0;
  endtask

  task automatic do_ack;
    ack = 1'b1; tick; ack = 1'b0;
  endtask

  task automatic do_eoi;
    eoi = 1'b1; tick; eoi = 1'b0;
  endtask

  // Highest-priority active id starting from 'start', or -1
  function automatic int pick(input int active, input int start);
    for (int i = 0; i < NUM_IRQ; i++) begin
      int id;
      id = (start + i) % NUM_IRQ;
      if (((active >> id) & 1) == 1) return id;
    end
    return -1;
  endfunction

  task automatic test_reset;
    logic [15:0] d;
    do_reset;
    n_total++; if (req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", req); end
    n_total++; if (vector !== 16'h0) begin n_bad++; $display("FAIL reset_vector: got %h want 0000", vector); end
    n_total++; if (rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    cfg_read(2'd0, d);
    n_total++; if (d !== 16'h00FF) begin n_bad++; $display("FAIL reset_mask: got %h want 00ff", d); end
    cfg_read(2'd1, d);
    n_total++; if (d !== 16'h0000) begin n_bad++; $display("FAIL reset_pending: got %h want 0000", d); end
    cfg_read(2'd2, d);
    n_total++; if (d !== 16'h0000) begin n_bad++; $display("FAIL reset_base: got %h want 0000", d); end
  endtask

  task automatic test_basic;
    logic [15:0] d;
    cfg_write(2'd0, 16'h0000);
    cfg_write(2'd2, 16'h0100);
    pulse_irq(8'h08);
    n_total++; if (req !== 1'b0) begin n_bad++; $display("FAIL basic_req_early: got %b want 0", req); end
    cfg_read(2'd1, d);
    n_total++; if (d !== 16'h0008) begin n_bad++; $display("FAIL basic_pending: got %h want 0008", d); end
    n_total++; if (req !== 1'b1) begin n_bad++; $display("FAIL basic_req: got %b want 1", req); end
    n_total++; if (vector !== 16'h010C) begin n_bad++; $display("FAIL basic_vector: got %h want 010c", vector); end
    do_ack;
    n_total++; if (req !== 1'b0) begin n_bad++; $display("FAIL basic_req_after_ack: got %b want 0", req); end
    cfg_read(2'd1, d);
    n_total++; if (d !== 16'h0000) begin n_bad++; $display("FAIL basic_pending_after_ack: got %h want 0000", d); end
    cfg_read(2'd3, d);
    n_total++; if ((d & 16'h0027) !== 16'h0023) begin n_bad++; $display("FAIL basic_status_service: got %h want 0023 under mask 0027", d & 16'h0027); end
    do_eoi;
    cfg_read(2'd3, d);
    n_total++; if ((d & 16'h0020) !== 16'h0000) begin n_bad++; $display("FAIL basic_status_idle: got %h want 0000 under mask 0020", d & 16'h0020); end
  endtask

  task automatic test_priority;
    logic [15:0] exp_a, exp_b;
`ifdef INT_ROTATE_PRI_EN
    exp_a = 16'h0114; exp_b = 16'h0100;
`else
    exp_a = 16'h0100; exp_b = 16'h0114;
`endif
    do_reset;
    cfg_write(2'd0, 16'h0000);
    cfg_write(2'd2, 16'h0100);
    pulse_irq(8'h24);
    tick;
    n_total++; if (req !== 1'b1 || vector !== 16'h0108) begin n_bad++; $display("FAIL prio_first: got req=%b vec=%h want req=1 vec=0108", req, vector); end
    do_ack; do_eoi; tick;
    n_total++; if (req !== 1'b1 || vector !== 16'h0114) begin n_bad++; $display("FAIL prio_second: got req=%b vec=%h want req=1 vec=0114", req, vector); end
    do_ack; do_eoi;
    pulse_irq(8'h04);
    tick;
    n_total++; if (req !== 1'b1 || vector !== 16'h0108) begin n_bad++; $display("FAIL prio_id2: got req=%b vec=%h want req=1 vec=0108", req, vector); end
    do_ack;
    pulse_irq(8'h21);
    do_eoi; tick;
    n_total++; if (req !== 1'b1 || vector !== exp_a) begin n_bad++; $display("FAIL prio_after_id2: got req=%b vec=%h want req=1 vec=%h", req, vector, exp_a); end
    do_ack; do_eoi; tick;
    n_total++; if (req !== 1'b1 || vector !== exp_b) begin n_bad++; $display("FAIL prio_last: got req=%b vec=%h want req=1 vec=%h", req, vector, exp_b); end
    do_ack; do_eoi;
  endtask

  task automatic test_mask;
    logic [15:0] d;
    int k;
    cfg_write(2'd0, 16'h0010);
    pulse_irq(8'h10);
    tick; tick;
    n_total++; if (req !== 1'b0) begin n_bad++; $display("FAIL mask_req_blocked: got %b want 0", req); end
    cfg_read(2'd1, d);
    n_total++; if (d !== 16'h0010) begin n_bad++; $display("FAIL mask_pending: got %h want 0010", d); end
    cfg_write(2'd0, 16'h0000);
    k = 0;
    while (req !== 1'b1 && k < 2) begin tick; k++; end
    n_total++; if (req !== 1'b1) begin n_bad++; $display("FAIL mask_release_req: got %b want 1 within 2 clks", req); end
    n_total++; if (vector !== 16'h0110) begin n_bad++; $display("FAIL mask_release_vector: got %h want 0110", vector); end
    do_ack; do_eoi;
  endtask

  task automatic test_hold_w1c;
    logic [15:0] d;
    cfg_write(2'd0, 16'h00FF);
    irq = 8'h02;
    repeat (10) tick;
    cfg_read(2'd1, d);
    n_total++; if (d !== 16'h0002) begin n_bad++; $display("FAIL hold_pending: got %h want 0002", d); end
    cfg_write(2'd1, 16'h0002);
    cfg_read(2'd1, d);
    n_total++; if (d !== 16'h0000) begin n_bad++; $display("FAIL hold_no_retrigger: got %h want 0000", d); end
    irq = 8'h00;
    tick;
    irq = 8'h02; we = 1'b1; addr = 2'd1; wdata = 16'h0002;
    tick;
    we = 1'b0; irq = 8'h00;
    cfg_read(2'd1, d);
    n_total++; if (d !== 16'h0002) begin n_bad++; $display("FAIL w1c_set_wins: got %h want 0002", d); end
    cfg_write(2'd1, 16'h0002);
    cfg_write(2'd0, 16'h0000);
  endtask

  task automatic test_service_accum;
    logic [15:0] d;
    pulse_irq(8'h01);
    tick;
    n_total++; if (req !== 1'b1 || vector !== 16'h0100) begin n_bad++; $display("FAIL svc_first: got req=%b vec=%h want req=1 vec=0100", req, vector); end
    do_ack;
    pulse_irq(8'h40);
    n_total++; if (req !== 1'b0) begin n_bad++; $display("FAIL svc_no_nest: got %b want 0", req); end
    cfg_read(2'd1, d);
    n_total++; if (d !== 16'h0040) begin n_bad++; $display("FAIL svc_pending: got %h want 0040", d); end
    n_total++; if (req !== 1'b0) begin n_bad++; $display("FAIL svc_still_blocked: got %b want 0", req); end
    do_eoi;
    n_total++; if (req !== 1'b0) begin n_bad++; $display("FAIL svc_eoi_cycle: got %b want 0", req); end
    tick;
    n_total++; if (req !== 1'b1 || vector !== 16'h0118) begin n_bad++; $display("FAIL svc_next_req: got req=%b vec=%h want req=1 vec=0118", req, vector); end
  endtask

  task automatic test_reset_in_req;
    logic [15:0] d;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_total++; if (req !== 1'b0) begin n_bad++; $display("FAIL rstreq_req: got %b want 0", req); end
    n_total++; if (rdata !== 16'h0000) begin n_bad++; $display("FAIL rstreq_rdata: got %h want 0000", rdata); end
    cfg_read(2'd1, d);
    n_total++; if (d !== 16'h0000) begin n_bad++; $display("FAIL rstreq_pending: got %h want 0000", d); end
    cfg_read(2'd0, d);
    n_total++; if (d !== 16'h00FF) begin n_bad++; $display("FAIL rstreq_mask: got %h want 00ff", d); end
    n_total++; if (req !== 1'b0) begin n_bad++; $display("FAIL rstreq_stays_idle: got %b want 0", req); end
  endtask

  task automatic test_random;
    int edge_v, active, np, w;
    do_reset;
    m_mask = 255; m_pend = 0; m_base = 0; m_prev = 0; m_phase = 0;
    m_sel = 0; m_vec = 0; m_ptr = 0; m_rdata = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      irq   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      we    = ($urandom_range(0, 5) == 0);
      re    = ($urandom_range(0, 3) == 0);
      addr  = 2'($urandom_range(0, 2));
      wdata = 16'($urandom);
      if (addr == 2'd0) wdata = wdata & 16'($urandom);
      ack   = ($urandom_range(0, 2) == 0);
      eoi   = ($urandom_range(0, 2) == 0);

      edge_v = int'(irq) & ~m_prev & 255;
      active = m_pend & ~m_mask & 255;
      np = m_pend;
      if (re) m_rdata = (addr == 2'd0) ? m_mask : (addr == 2'd1) ? m_pend : m_base;
      if (we && addr == 2'd1) np = np & ~int'(wdata);
      if (m_phase == 0) begin
        w = pick(active, m_ptr);
        if (w >= 0) begin
          m_sel = w;
          m_vec = (m_base + (w << VEC_SHIFT)) % 65536;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (ack) begin
          np = np & ~(1 << m_sel);
          m_phase = 2;
`ifdef INT_ROTATE_PRI_EN
          m_ptr = (m_sel + 1) % NUM_IRQ;
`endif
        end
      end else begin
        if (eoi) m_phase = 0;
      end
      if (we && addr == 2'd0) m_mask = int'(wdata) & 255;
      if (we && addr == 2'd2) m_base = int'(wdata);
      m_pend = np | edge_v;
      m_prev = int'(irq);

      tick;

      n_total++; if (req !== (m_phase == 1)) begin n_bad++; $display("FAIL rand_req cyc %0d: got %b want %b", cyc, req, (m_phase == 1)); end
      if (m_phase == 1) begin
        n_total++; if (vector !== 16'(m_vec)) begin n_bad++; $display("FAIL rand_vector cyc %0d: got %h want %h", cyc, vector, 16'(m_vec)); end
      end
      n_total++; if (rdata !== 16'(m_rdata)) begin n_bad++; $display("FAIL rand_rdata cyc %0d: got %h want %h", cyc, rdata, 16'(m_rdata)); end
    end
    irq = '0; we = 1'b0; re = 1'b0; ack = 1'b0; eoi = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_priority;
    test_mask;
    test_hold_w1c;
    test_service_accum;
    test_reset_in_req;
    test_random;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
